// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bpu_pkg
// Brief    : Shared types, counter encodings and helpers for the BPU update path
// Revision : 1.0 - initial release
// ============================================================================
package bpu_pkg;

    localparam int IDX_W_DFLT = 10;
    localparam int TAG_W_DFLT = 8;

    localparam logic [1:0] HIST_SNT = 2'b00;
    localparam logic [1:0] HIST_WNT = 2'b01;
    localparam logic [1:0] HIST_WT  = 2'b10;
    localparam logic [1:0] HIST_ST  = 2'b11;

    typedef struct packed {
        logic [IDX_W_DFLT-1:0] index;
        logic [TAG_W_DFLT-1:0] tag;
        logic                  taken;
        logic [31:0]           target;
        logic                  is_ret;
    } bpu_upd_t;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } bpu_state_e;

    // Both weak states promote straight to strongly-taken on a taken branch.
    function automatic logic [1:0] hist_next(input logic [1:0] hist, input logic taken);
        logic [1:0] nxt;
        nxt = HIST_SNT;
        case (hist)
            HIST_SNT: nxt = taken ? HIST_WNT : HIST_SNT;
            HIST_WNT: nxt = taken ? HIST_ST  : HIST_SNT;
            HIST_WT:  nxt = taken ? HIST_ST  : HIST_SNT;
            HIST_ST:  nxt = taken ? HIST_ST  : HIST_WT;
            default:  nxt = HIST_SNT;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bpu_upd_fifo
// Brief    : Synchronous in-order FIFO holding pending branch updates
// Revision : 1.0 - initial release
// ============================================================================
module bpu_upd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    import bpu_pkg::*;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpu_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bpu_update_ctrl
// Brief    : Owns the BHT/BTB write port: invalidate sweep plus queued RMW updates
// Revision : 1.0 - initial release
// ============================================================================
module bpu_update_ctrl
    import bpu_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DFLT,
    parameter int TAG_W      = TAG_W_DFLT,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_index,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_is_ret,
    input  logic             flush_all,
    output logic [IDX_W-1:0] tbl_rd_index,
    input  logic             tbl_rd_valid,
    input  logic [TAG_W-1:0] tbl_rd_tag,
    input  logic [1:0]       tbl_rd_hist,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_wr_index,
    output logic             tbl_wr_valid,
    output logic [TAG_W-1:0] tbl_wr_tag,
    output logic [1:0]       tbl_wr_hist,
    output logic             tbl_wr_target_en,
    output logic [31:0]      tbl_wr_target,
    output logic             tbl_wr_is_ret,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_cnt
);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [31:0]      target;
        logic             is_ret;
    } upd_t;

    localparam logic [IDX_W-1:0] c_SWP_LAST = '1;

    bpu_state_e       r_state;
    logic [IDX_W-1:0] r_swp;
    upd_t             w_in;
    upd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_hit;

    assign w_in      = '{index: upd_index, tag: upd_tag, taken: upd_taken,
                         target: upd_target, is_ret: upd_is_ret};
    assign upd_ready = !w_full;
    assign busy      = (r_state == SWEEP);
    assign w_pop     = (r_state == RUN) && !w_empty;
    assign tbl_rd_index = w_head.index;
    assign w_hit     = tbl_rd_valid && (tbl_rd_tag == w_head.tag);

    bpu_upd_fifo #(
        .WIDTH ($bits(upd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (cpu_clk),
        .i_rst   (cpu_rst),
        .i_clear (flush_all),
        .i_push  (upd_valid),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_cnt)
    );

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || flush_all) begin
            r_state <= SWEEP;
            r_swp   <= '0;
        end else if (r_state == SWEEP) begin
            r_swp <= r_swp + IDX_W'(1);
            if (r_swp == c_SWP_LAST) begin
                r_state <= RUN;
            end
        end
    end

    always_comb begin
        tbl_we           = 1'b0;
        tbl_wr_index     = r_swp;
        tbl_wr_valid     = 1'b0;
        tbl_wr_tag       = '0;
        tbl_wr_hist      = HIST_WT;
        tbl_wr_target_en = 1'b0;
        tbl_wr_target    = w_head.target;
        tbl_wr_is_ret    = 1'b0;
        case (r_state)
            SWEEP: tbl_we = 1'b1;
            RUN: begin
                if (!w_empty) begin
                    tbl_wr_index  = w_head.index;
                    tbl_wr_valid  = 1'b1;
                    tbl_wr_tag    = w_head.tag;
                    tbl_wr_is_ret = w_head.is_ret;
                    if (w_hit) begin
                        tbl_we           = 1'b1;
                        tbl_wr_hist      = hist_next(tbl_rd_hist, w_head.taken);
                        tbl_wr_target_en = w_head.taken;
                    end else if (w_head.taken) begin
                        tbl_we           = 1'b1;
                        tbl_wr_target_en = 1'b1;
                    end
                end
            end
            default: tbl_we = 1'b0;
        endcase
        // A flushed head must not reach the table, and reset never writes.
        if (cpu_rst || flush_all) begin
            tbl_we = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bpu_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpu_update_ctrl
// Brief    : Directed self-checking bench for bpu_update_ctrl (IDX_W=4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpu_update_ctrl;

    localparam int IDX_W = 4;
    localparam int TAG_W = 8;
    localparam int DEPTH = 4;

    logic             cpu_clk;
    logic             cpu_rst;
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_index;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             upd_is_ret;
    logic             flush_all;
    logic [IDX_W-1:0] tbl_rd_index;
    logic             tbl_rd_valid;
    logic [TAG_W-1:0] tbl_rd_tag;
    logic [1:0]       tbl_rd_hist;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_wr_index;
    logic             tbl_wr_valid;
    logic [TAG_W-1:0] tbl_wr_tag;
    logic [1:0]       tbl_wr_hist;
    logic             tbl_wr_target_en;
    logic [31:0]      tbl_wr_target;
    logic             tbl_wr_is_ret;
    logic             busy;
    logic [2:0]       fifo_cnt;

    int n_cmp;
    int n_bad;

    bpu_update_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
        .upd_tag(upd_tag), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_is_ret(upd_is_ret), .flush_all(flush_all),
        .tbl_rd_index(tbl_rd_index), .tbl_rd_valid(tbl_rd_valid),
        .tbl_rd_tag(tbl_rd_tag), .tbl_rd_hist(tbl_rd_hist),
        .tbl_we(tbl_we), .tbl_wr_index(tbl_wr_index), .tbl_wr_valid(tbl_wr_valid),
        .tbl_wr_tag(tbl_wr_tag), .tbl_wr_hist(tbl_wr_hist),
        .tbl_wr_target_en(tbl_wr_target_en), .tbl_wr_target(tbl_wr_target),
        .tbl_wr_is_ret(tbl_wr_is_ret), .busy(busy), .fifo_cnt(fifo_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_upd(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                           input logic taken, input logic [31:0] tgt, input logic is_ret);
        upd_index  = idx;
        upd_tag    = tag;
        upd_taken  = taken;
        upd_target = tgt;
        upd_is_ret = is_ret;
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1; flush_all = 1'b0; upd_valid = 1'b0;
        set_upd('0, '0, 1'b0, '0, 1'b0);
        tbl_rd_valid = 1'b0; tbl_rd_tag = '0; tbl_rd_hist = 2'b00;
        tick(); tick();
        n_cmp++; if (tbl_we !== 1'b0) begin n_bad++; $display("FAIL rst_we_gated: got %b want 0", tbl_we); end
        cpu_rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %b want 1", busy); end
        n_cmp++; if (tbl_we !== 1'b1) begin n_bad++; $display("FAIL rst_we: got %b want 1", tbl_we); end
        n_cmp++; if (tbl_wr_target_en !== 1'b0 || tbl_wr_is_ret !== 1'b0) begin
            n_bad++; $display("FAIL rst_ten_ret: got %b%b want 00", tbl_wr_target_en, tbl_wr_is_ret); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", upd_ready); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", fifo_cnt); end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (tbl_we !== 1'b1 || tbl_wr_index !== 4'(i) || tbl_wr_valid !== 1'b0 ||
                tbl_wr_hist !== 2'b10 || tbl_wr_tag !== 8'h00 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL sweep_%0d: got we=%b idx=%0d v=%b h=%b tag=%h busy=%b want we=1 idx=%0d v=0 h=10 tag=00 busy=1",
                         i, tbl_we, tbl_wr_index, tbl_wr_valid, tbl_wr_hist, tbl_wr_tag, busy, i);
            end
            tick();
        end
        n_cmp++; if (busy !== 1'b0 || tbl_we !== 1'b0) begin
            n_bad++; $display("FAIL sweep_done: got busy=%b we=%b want 0 0", busy, tbl_we); end
    endtask

    task automatic test_alloc();
        set_upd(4'd5, 8'hA1, 1'b1, 32'h1C000100, 1'b0);
        upd_valid = 1'b1; tbl_rd_valid = 1'b0;
        #1;
        n_cmp++; if (tbl_we !== 1'b0) begin n_bad++; $display("FAIL alloc_idle_we: got %b want 0", tbl_we); end
        tick();
        upd_valid = 1'b0;
        #1;
        n_cmp++; if (tbl_rd_index !== 4'd5) begin n_bad++; $display("FAIL alloc_rd_idx: got %0d want 5", tbl_rd_index); end
        n_cmp++;
        if (tbl_we !== 1'b1 || tbl_wr_index !== 4'd5 || tbl_wr_valid !== 1'b1 || tbl_wr_tag !== 8'hA1 ||
            tbl_wr_hist !== 2'b10 || tbl_wr_target_en !== 1'b1 || tbl_wr_target !== 32'h1C000100 || tbl_wr_is_ret !== 1'b0) begin
            n_bad++;
            $display("FAIL alloc_write: got we=%b idx=%0d v=%b tag=%h h=%b ten=%b tgt=%h ret=%b want 1 5 1 a1 10 1 1c000100 0",
                     tbl_we, tbl_wr_index, tbl_wr_valid, tbl_wr_tag, tbl_wr_hist, tbl_wr_target_en, tbl_wr_target, tbl_wr_is_ret);
        end
        n_cmp++; if (fifo_cnt !== 3'd1) begin n_bad++; $display("FAIL alloc_cnt: got %0d want 1", fifo_cnt); end
        tick();
        n_cmp++; if (fifo_cnt !== 3'd0 || tbl_we !== 1'b0) begin
            n_bad++; $display("FAIL alloc_drained: got cnt=%0d we=%b want 0 0", fifo_cnt, tbl_we); end
    endtask

    task automatic test_hit();
        logic [1:0] rd_h   [5] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00};
        logic       tk     [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] want_h [5] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b01};
        logic       ret    [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            set_upd(4'd5, 8'hA1, tk[i], 32'h1C000200 + 32'(i), ret[i]);
            upd_valid = 1'b1;
            tick();
            upd_valid = 1'b0;
            tbl_rd_valid = 1'b1; tbl_rd_tag = 8'hA1; tbl_rd_hist = rd_h[i];
            #1;
            n_cmp++;
            if (tbl_we !== 1'b1 || tbl_wr_hist !== want_h[i] || tbl_wr_valid !== 1'b1 ||
                tbl_wr_target_en !== tk[i] || tbl_wr_is_ret !== ret[i] ||
                (tk[i] && tbl_wr_target !== 32'h1C000200 + 32'(i))) begin
                n_bad++;
                $display("FAIL hit_%0d: got we=%b h=%b v=%b ten=%b ret=%b tgt=%h want 1 %b 1 %b %b %h",
                         i, tbl_we, tbl_wr_hist, tbl_wr_valid, tbl_wr_target_en, tbl_wr_is_ret,
                         tbl_wr_target, want_h[i], tk[i], ret[i], 32'h1C000200 + 32'(i));
            end
            tick();
        end
    endtask

    task automatic test_miss();
        set_upd(4'd5, 8'hA1, 1'b0, 32'h0, 1'b0);
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        tbl_rd_valid = 1'b1; tbl_rd_tag = 8'h3C; tbl_rd_hist = 2'b11;
        #1;
        n_cmp++; if (tbl_we !== 1'b0 || fifo_cnt !== 3'd1) begin
            n_bad++; $display("FAIL miss_nt: got we=%b cnt=%0d want 0 1", tbl_we, fifo_cnt); end
        tick();
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL miss_nt_pop: got %0d want 0", fifo_cnt); end
        set_upd(4'd9, 8'hA1, 1'b1, 32'h1C000300, 1'b1);
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        #1;
        n_cmp++;
        if (tbl_we !== 1'b1 || tbl_wr_index !== 4'd9 || tbl_wr_tag !== 8'hA1 || tbl_wr_hist !== 2'b10 ||
            tbl_wr_target_en !== 1'b1 || tbl_wr_is_ret !== 1'b1 || tbl_wr_target !== 32'h1C000300) begin
            n_bad++;
            $display("FAIL miss_replace: got we=%b idx=%0d tag=%h h=%b ten=%b ret=%b tgt=%h want 1 9 a1 10 1 1 1c000300",
                     tbl_we, tbl_wr_index, tbl_wr_tag, tbl_wr_hist, tbl_wr_target_en, tbl_wr_is_ret, tbl_wr_target);
        end
        tick();
        tbl_rd_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        flush_all = 1'b1;
        tick();
        flush_all = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || tbl_wr_index !== 4'd0) begin
            n_bad++; $display("FAIL b2b_sweep_start: got busy=%b idx=%0d want 1 0", busy, tbl_wr_index); end
        for (int k = 0; k < 5; k++) begin
            set_upd(4'(k), 8'h10 + 8'(k), 1'b1, 32'h1C001000 + 32'(k), 1'b0);
            upd_valid = 1'b1;
            #1;
            n_cmp++;
            if (upd_ready !== (k < 4) || fifo_cnt !== 3'((k < 4) ? k : 4)) begin
                n_bad++;
                $display("FAIL b2b_push_%0d: got ready=%b cnt=%0d want %b %0d", k, upd_ready, fifo_cnt,
                         (k < 4), (k < 4) ? k : 4);
            end
            tick();
        end
        upd_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n_cmp++; if (fifo_cnt !== 3'd4) begin n_bad++; $display("FAIL b2b_hold: got %0d want 4", fifo_cnt); end
            tick();
            n++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: got busy=%b want 0", busy); end
        n_cmp++;
        if (fifo_cnt !== 3'd4 || tbl_we !== 1'b1 || tbl_wr_index !== 4'd0 || tbl_wr_tag !== 8'h10) begin
            n_bad++;
            $display("FAIL b2b_first_drain: got cnt=%0d we=%b idx=%0d tag=%h want 4 1 0 10",
                     fifo_cnt, tbl_we, tbl_wr_index, tbl_wr_tag);
        end
        tick();
        n_cmp++; if (fifo_cnt !== 3'd3 || tbl_rd_index !== 4'd1) begin
            n_bad++; $display("FAIL b2b_second: got cnt=%0d rd_idx=%0d want 3 1", fifo_cnt, tbl_rd_index); end
    endtask

    task automatic test_flush();
        int n;
        flush_all = 1'b1;
        set_upd(4'd7, 8'h77, 1'b1, 32'h0, 1'b0);
        upd_valid = 1'b1;
        #1;
        n_cmp++; if (tbl_we !== 1'b0) begin n_bad++; $display("FAIL flush_run_we: got %b want 0", tbl_we); end
        tick();
        flush_all = 1'b0; upd_valid = 1'b0;
        #1;
        n_cmp++;
        if (fifo_cnt !== 3'd0 || busy !== 1'b1 || tbl_we !== 1'b1 || tbl_wr_index !== 4'd0) begin
            n_bad++;
            $display("FAIL flush_run_after: got cnt=%0d busy=%b we=%b idx=%0d want 0 1 1 0",
                     fifo_cnt, busy, tbl_we, tbl_wr_index);
        end
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (tbl_wr_index !== 4'd7) begin n_bad++; $display("FAIL flush_swp7: got %0d want 7", tbl_wr_index); end
        flush_all = 1'b1;
        #1;
        n_cmp++; if (tbl_we !== 1'b0) begin n_bad++; $display("FAIL flush_sweep_we: got %b want 0", tbl_we); end
        tick();
        flush_all = 1'b0;
        #1;
        n_cmp++; if (tbl_wr_index !== 4'd0 || busy !== 1'b1 || tbl_we !== 1'b1) begin
            n_bad++; $display("FAIL flush_sweep_restart: got idx=%0d busy=%b we=%b want 0 1 1", tbl_wr_index, busy, tbl_we); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 16 || tbl_we !== 1'b0) begin
            n_bad++; $display("FAIL flush_sweep_len: got cycles=%0d we=%b want 16 0", n, tbl_we); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_sweep();
        test_alloc();
        test_hit();
        test_miss();
        test_back_to_back();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bpu_update_ctrl.md
Name: bpu_update_ctrl

Overview:
Owns the single write port of the BHT/BTB table storage. It buffers branch-resolution updates from EX in a small in-order FIFO and drains them one per cycle as read-modify-write operations against the tables. It also sequences a full-table invalidate sweep after reset and on flush_all. While the sweep runs, it raises busy so the predictor forces not-taken.

Parameters:
IDX_W, 10, table index width; the sweep length is 2^IDX_W cycles.
TAG_W, 8, tag width.
FIFO_DEPTH, 4, update queue depth; must be a power of two and at least 2.

Ports:
cpu_clk  in  1  clock.
cpu_rst  in  1  synchronous active-high reset.
upd_valid  in  1  EX update request.
upd_ready  out  1  request accepted when upd_valid && upd_ready.
upd_index  in  IDX_W  table index of the resolved branch.
upd_tag  in  TAG_W  tag of the resolved branch.
upd_taken  in  1  real direction.
upd_target  in  32  real target.
upd_is_ret  in  1  branch is a ret.
flush_all  in  1  one-cycle invalidate-all request.
tbl_rd_index  out  IDX_W  asynchronous read index, driven with the FIFO head index.
tbl_rd_valid  in  1  valid bit at tbl_rd_index, same cycle.
tbl_rd_tag  in  TAG_W  tag at tbl_rd_index, same cycle.
tbl_rd_hist  in  2  2-bit counter at tbl_rd_index, same cycle.
tbl_we  out  1  write strobe; the table latches on this cpu_clk edge.
tbl_wr_index  out  IDX_W  write index.
tbl_wr_valid  out  1  valid bit to write.
tbl_wr_tag  out  TAG_W  tag to write.
tbl_wr_hist  out  2  counter to write.
tbl_wr_target_en  out  1  target field written only when 1.
tbl_wr_target  out  32  target to write.
tbl_wr_is_ret  out  1  is_ret bit to write.
busy  out  1  sweep in progress; the predictor must predict not-taken.
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- States: SWEEP, RUN. The sweep pointer swp is IDX_W bits wide.
- Reset (cpu_rst=1 at an edge):
  - state=SWEEP, swp=0, FIFO empty.
  - The first cycle after reset shows: busy=1, tbl_we=1, tbl_wr_index=0, tbl_wr_valid=0, tbl_wr_hist=2'b10, tbl_wr_target_en=0, tbl_wr_is_ret=0, upd_ready=1, fifo_cnt=0.
- SWEEP:
  - Each cycle write entry swp with valid=0, hist=2'b10, is_ret=0, target_en=0, tag=0.
  - swp increments by 1.
  - When swp reaches 2^IDX_W-1, that write completes the sweep and the next state is RUN. Exactly 2^IDX_W writes occur.
  - FIFO accepts pushes while not full but does not drain.
- RUN, FIFO non-empty: head H is processed combinationally; tbl_rd_index=H.index.
  - hit = tbl_rd_valid && tbl_rd_tag==H.tag.
  - Hit case:
    - we=1, valid=1, tag=H.tag.
    - hist follows the saturating table:
      - 00: taken→01, else 00.
      - 01: taken→11, else 00.
      - 10: taken→11, else 00.
      - 11: taken→11, else 10.
    - target_en=H.taken, target=H.target.
    - is_ret=1 if H.is_ret was 1, otherwise 0. This is sticky only through the update path.
  - Miss with H.taken (allocate or replace): we=1, valid=1, tag=H.tag, hist=10, target_en=1, is_ret=H.is_ret.
  - Miss with not taken: we=0.
  - The head pops every RUN cycle while the FIFO is non-empty, whether or not a write occurred.
- RUN, FIFO empty: we=0, busy=0.
- Latency: an update pushed at edge t is written at edge t+1 when the FIFO was empty and state=RUN.
- Order: strictly FIFO. Two updates to the same index in consecutive cycles see each other's result through the table read, because the write at edge t is visible to the async read in cycle t+1.
- upd_ready = !full. Push and pop in the same cycle are legal when full: ready stays 0 that cycle, and capacity frees next cycle.
- fifo_cnt updates by +1 on push, -1 on pop, unchanged on simultaneous push and pop. It never exceeds FIFO_DEPTH.
- flush_all (synchronous, effective at the edge):
  - FIFO is cleared, including any push in the same cycle and the current head. The head's write in that cycle is suppressed: tbl_we is forced to 0 in the flush cycle.
  - Next state is SWEEP with swp=0.
  - flush_all during SWEEP restarts the sweep from 0.
- cpu_rst has priority over flush_all. Reset mid-sweep restarts from 0.
- Table writes never occur while cpu_rst=1: tbl_we is gated off.

Decomposition:
- Package bpu_pkg:
  - IDX_W/TAG_W defaults.
  - Counter encodings HIST_SNT=00, HIST_WNT=01, HIST_WT=10, HIST_ST=11.
  - bpu_upd_t packed struct {index, tag, taken, target, is_ret}.
  - Function hist_next(hist, taken).
  - State enum {SWEEP, RUN}.
- Sub-module bpu_upd_fifo: synchronous FIFO of bpu_upd_t with push/pop/clear/full/empty/count.
- The controller FSM and RMW logic stay in bpu_update_ctrl.

Test Plan:
1. Reset, then idle with IDX_W=4. Expect tbl_we high for 16 cycles with indices 0..15, all writing valid=0 and hist=10. busy falls after the cycle that writes index 15.
2. After the sweep, push {idx=5, tag=0xA1, taken=1, target=0x1C000100} with rd_valid=0. Expect one write next cycle: valid=1, tag=A1, hist=10, target_en=1, target=0x1C000100.
3. Hit at idx 5 with rd_hist=10: push taken → write hist=11. Then rd_hist=11, not taken → hist=10 with target_en=0. Then rd_hist=00, not taken → hist=00.
4. Miss, not taken, with rd_valid=1 and rd_tag=0x3C ≠ 0xA1. Expect tbl_we=0, head popped, fifo_cnt decrements.
5. Hold the table read stalled by asserting flush_all... no: push 5 updates back-to-back during SWEEP with FIFO_DEPTH=4. Expect upd_ready=0 on the 5th, fifo_cnt=4, and draining starts the first RUN cycle.
6. With 3 queued entries in RUN, pulse flush_all. Expect tbl_we=0 that cycle, fifo_cnt=0 next cycle, busy=1, sweep restarting at index 0. A flush_all at swp=7 during SWEEP restarts at 0.
